// File: rtl/itlb_refill_pkg.sv
// Shared definitions for the iTLB refill walker: FSM state encoding,
// PTE field positions and small PTE decode helpers.
package itlb_refill_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FILL  = 3'd3,
        ST_FAULT = 3'd4,
        ST_DRAIN = 3'd5
    } itlb_state_e;

    // PTE layout: valid flag in the top bit, PPN in the low bits.
    localparam int PTE_VALID_BIT = 31;

    // Fault cause encoding reported on fault_cause.
    localparam logic CAUSE_INVALID = 1'b0;
    localparam logic CAUSE_TIMEOUT = 1'b1;

    function automatic logic pte_valid(input logic [31:0] pte);
        return pte[PTE_VALID_BIT];
    endfunction

endpackage

// File: rtl/itlb_refill.sv
// iTLB refill walker: on a miss, reads one PTE from ptbr + 4*vpn, then either
// fills the iTLB or reports a page fault. A flushed or timed-out walk waits in
// DRAIN for the orphaned memory response so it can never be mistaken for the
// response of a later walk.
module itlb_refill
    import itlb_refill_pkg::*;
#(
    parameter int VPN_W   = 20,
    parameter int PPN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             tlb_miss,
    input  logic [31:0]      miss_vaddr,
    input  logic [31:0]      ptbr,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             tlb_write,
    output logic [VPN_W-1:0] reg_logic_page,
    output logic [PPN_W-1:0] reg_physical_page,
    output logic             busy,
    output logic             page_fault,
    output logic             fault_cause
);

    localparam int CNT_W    = $clog2(TIMEOUT + 1);
    localparam int ADDR_PAD = 32 - VPN_W - 2;

    itlb_state_e      state_r;
    itlb_state_e      state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [VPN_W-1:0] vpn_r;
    logic [31:0]      walk_addr_s;
    logic             take_miss_s;
    logic             fill_s;
    logic             fault_s;
    logic             cause_s;

    logic             mem_req_r;
    logic [31:0]      mem_addr_r;
    logic             tlb_write_r;
    logic [VPN_W-1:0] logic_page_r;
    logic [PPN_W-1:0] phys_page_r;
    logic             busy_r;
    logic             page_fault_r;
    logic             fault_cause_r;

    // PTE reserved bits and the page offset play no part in the walk.
    logic             unused_s;
    assign unused_s = &{1'b0, mem_rdata[30:PPN_W], miss_vaddr[31-VPN_W:0]};

    // PTE address for the missing page, wrapping modulo 2^32.
    assign walk_addr_s = ptbr + {{ADDR_PAD{1'b0}}, miss_vaddr[31 -: VPN_W], 2'b00};
    assign cnt_inc_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state decode; flush overrides every transition except leaving DRAIN.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        take_miss_s = 1'b0;
        fill_s      = 1'b0;
        fault_s     = 1'b0;
        cause_s     = fault_cause_r;
        case (state_r)
            ST_IDLE: begin
                if (tlb_miss && !flush) begin
                    state_s     = ST_REQ;
                    take_miss_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    // Once granted a response is owed, so it must be drained.
                    state_s = mem_gnt ? ST_DRAIN : ST_IDLE;
                end else if (mem_gnt) begin
                    state_s = ST_WAIT;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    // A response arriving with the flush is consumed right here.
                    state_s = mem_rvalid ? ST_IDLE : ST_DRAIN;
                end else if (mem_rvalid) begin
                    if (pte_valid(mem_rdata)) begin
                        state_s = ST_FILL;
                        fill_s  = 1'b1;
                    end else begin
                        state_s = ST_FAULT;
                        fault_s = 1'b1;
                        cause_s = CAUSE_INVALID;
                    end
                end else if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
                    state_s = ST_FAULT;
                    fault_s = 1'b1;
                    cause_s = CAUSE_TIMEOUT;
                    cnt_s   = cnt_inc_s;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_FILL: begin
                state_s = ST_IDLE;
            end
            ST_FAULT: begin
                // A timed-out request still has a response in flight.
                if (fault_cause_r == CAUSE_TIMEOUT) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, walk context and output registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            vpn_r         <= {VPN_W{1'b0}};
            mem_req_r     <= 1'b0;
            mem_addr_r    <= 32'h0000_0000;
            tlb_write_r   <= 1'b0;
            logic_page_r  <= {VPN_W{1'b0}};
            phys_page_r   <= {PPN_W{1'b0}};
            busy_r        <= 1'b0;
            page_fault_r  <= 1'b0;
            fault_cause_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            mem_req_r    <= (state_s == ST_REQ);
            busy_r       <= (state_s != ST_IDLE);
            tlb_write_r  <= fill_s;
            page_fault_r <= fault_s;
            if (take_miss_s) begin
                vpn_r      <= miss_vaddr[31 -: VPN_W];
                mem_addr_r <= walk_addr_s;
            end else begin
                vpn_r      <= vpn_r;
                mem_addr_r <= mem_addr_r;
            end
            if (fill_s) begin
                logic_page_r <= vpn_r;
                phys_page_r  <= mem_rdata[PPN_W-1:0];
            end else begin
                logic_page_r <= logic_page_r;
                phys_page_r  <= phys_page_r;
            end
            if (fault_s) begin
                fault_cause_r <= cause_s;
            end else begin
                fault_cause_r <= fault_cause_r;
            end
        end
    end

    // A flush landing in the FILL/FAULT cycle withdraws that cycle's strobe.
    assign tlb_write         = tlb_write_r & ~flush;
    assign page_fault        = page_fault_r & ~flush;
    assign mem_req           = mem_req_r;
    assign mem_addr          = mem_addr_r;
    assign reg_logic_page    = logic_page_r;
    assign reg_physical_page = phys_page_r;
    assign busy              = busy_r;
    assign fault_cause       = fault_cause_r;

endmodule

// File: tb/tb_itlb_refill.sv
// Directed testbench for itlb_refill with hand-computed expectations.
module tb_itlb_refill;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        tlb_miss;
    logic [31:0] miss_vaddr;
    logic [31:0] ptbr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        tlb_write;
    logic [19:0] reg_logic_page;
    logic [7:0]  reg_physical_page;
    logic        busy;
    logic        page_fault;
    logic        fault_cause;

    int n_tests;
    int n_fail;
    int wr_cnt;
    int pf_cnt;
    int both_cnt;
    int wr_base;
    int pf_base;
    int n;

    itlb_refill dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .tlb_miss          (tlb_miss),
        .miss_vaddr        (miss_vaddr),
        .ptbr              (ptbr),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_gnt           (mem_gnt),
        .mem_rvalid        (mem_rvalid),
        .mem_rdata         (mem_rdata),
        .tlb_write         (tlb_write),
        .reg_logic_page    (reg_logic_page),
        .reg_physical_page (reg_physical_page),
        .busy              (busy),
        .page_fault        (page_fault),
        .fault_cause       (fault_cause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Strobe monitor sampling 1 ns before each rising edge.
    initial begin
        wr_cnt   = 0;
        pf_cnt   = 0;
        both_cnt = 0;
        forever begin
            @(negedge clk);
            #4;
            if (tlb_write) wr_cnt++;
            if (page_fault) pf_cnt++;
            if (tlb_write && page_fault) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a miss for one edge; returns with the walker in REQ.
    task automatic start_walk(input logic [31:0] va, input logic [31:0] base);
        tlb_miss   = 1'b1;
        miss_vaddr = va;
        ptbr       = base;
        tick();
        tlb_miss   = 1'b0;
    endtask

    task automatic grant_now();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0000_0000;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        flush      = 1'b0;
        tlb_miss   = 1'b0;
        miss_vaddr = 32'h0000_0000;
        ptbr       = 32'h0000_0000;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0000_0000;
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_req", {31'd0, mem_req}, 32'd0);
        check("reset_addr", mem_addr, 32'h0000_0000);
        check("reset_strobes", {30'd0, tlb_write, page_fault}, 32'd0);

        // Successful fill with immediate grant.
        start_walk(32'h0040_3ABC, 32'h0000_1000);
        check("fill_req", {31'd0, mem_req}, 32'd1);
        check("fill_addr", mem_addr, 32'h0000_200C);
        check("fill_busy", {31'd0, busy}, 32'd1);
        grant_now();
        check("fill_req_drop", {31'd0, mem_req}, 32'd0);
        respond(32'h8000_0055);
        check("fill_strobe", {31'd0, tlb_write}, 32'd1);
        check("fill_logic", {12'd0, reg_logic_page}, 32'h0000_0403);
        check("fill_phys", {24'd0, reg_physical_page}, 32'h0000_0055);
        check("fill_no_pf", {31'd0, page_fault}, 32'd0);
        tick();
        check("fill_strobe_1cyc", {31'd0, tlb_write}, 32'd0);
        check("fill_busy_drop", {31'd0, busy}, 32'd0);

        // Invalid PTE.
        wr_base = wr_cnt;
        start_walk(32'h0040_3ABC, 32'h0000_1000);
        grant_now();
        respond(32'h0000_0055);
        check("inv_pf", {31'd0, page_fault}, 32'd1);
        check("inv_cause", {31'd0, fault_cause}, 32'd0);
        check("inv_no_wr", {31'd0, tlb_write}, 32'd0);
        tick();
        check("inv_pf_1cyc", {31'd0, page_fault}, 32'd0);
        check("inv_idle", {31'd0, busy}, 32'd0);

        // Timeout after 255 WAIT cycles, then drain the late response.
        start_walk(32'h0000_5000, 32'h0000_0000);
        grant_now();
        n = 0;
        while (!page_fault && n < 400) begin
            tick();
            n++;
        end
        check("to_cycles", n, 32'd255);
        check("to_cause", {31'd0, fault_cause}, 32'd1);
        check("to_no_wr", {31'd0, tlb_write}, 32'd0);
        tick();
        tick();
        tick();
        check("to_drain_busy", {31'd0, busy}, 32'd1);
        check("to_drain_no_pf", {31'd0, page_fault}, 32'd0);
        respond(32'h8000_0077);
        check("to_drained_idle", {31'd0, busy}, 32'd0);
        check("to_total_wr", wr_cnt - wr_base, 32'd0);

        // Flush in WAIT, then the orphaned response.
        wr_base = wr_cnt;
        pf_base = pf_cnt;
        start_walk(32'h0001_1000, 32'h0000_1000);
        grant_now();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("fl_wait_drain", {31'd0, busy}, 32'd1);
        respond(32'h8000_0011);
        check("fl_wait_idle", {31'd0, busy}, 32'd0);
        tick();
        check("fl_wait_no_wr", wr_cnt - wr_base, 32'd0);
        check("fl_wait_no_pf", pf_cnt - pf_base, 32'd0);

        // Flush in REQ without grant returns straight to IDLE.
        start_walk(32'h0002_2000, 32'h0000_1000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_req_idle", {30'd0, busy, mem_req}, 32'd0);

        // Flush coincident with grant must drain.
        start_walk(32'h0002_2000, 32'h0000_1000);
        flush   = 1'b1;
        mem_gnt = 1'b1;
        tick();
        flush   = 1'b0;
        mem_gnt = 1'b0;
        check("fl_gnt_drain", {30'd0, busy, mem_req}, 32'd2);
        respond(32'h8000_0033);
        check("fl_gnt_idle", {31'd0, busy}, 32'd0);

        // Delayed grant; a second miss during the walk is ignored.
        start_walk(32'h1234_5000, 32'h0001_0000);
        tlb_miss   = 1'b1;
        miss_vaddr = 32'hFFFF_F000;
        ptbr       = 32'h0000_0000;
        for (int c = 0; c < 4; c++) begin
            check("dly_req", {31'd0, mem_req}, 32'd1);
            check("dly_addr", mem_addr, 32'h0005_8D14);
            if (c < 3) tick();
        end
        tlb_miss = 1'b0;
        grant_now();
        respond(32'h8000_0099);
        check("dly_logic", {12'd0, reg_logic_page}, 32'h0001_2345);
        check("dly_phys", {24'd0, reg_physical_page}, 32'h0000_0099);
        check("dly_wr", {31'd0, tlb_write}, 32'd1);
        tick();
        tick();
        check("dly_no_rewalk", {30'd0, busy, mem_req}, 32'd0);

        // Flush during the FILL cycle withdraws the strobe.
        start_walk(32'h0000_1000, 32'h0000_0000);
        grant_now();
        respond(32'h8000_0044);
        flush = 1'b1;
        #1;
        check("fl_fill_supp", {31'd0, tlb_write}, 32'd0);
        tick();
        flush = 1'b0;
        check("fl_fill_idle", {31'd0, busy}, 32'd0);

        // Reset mid-walk in WAIT (fault_cause still 1 from the timeout).
        start_walk(32'h0040_3ABC, 32'h0000_1000);
        grant_now();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", mem_addr, 32'h0000_0000);
        check("rst_logic", {12'd0, reg_logic_page}, 32'd0);
        check("rst_phys", {24'd0, reg_physical_page}, 32'd0);
        check("rst_cause", {31'd0, fault_cause}, 32'd0);
        check("rst_strobes", {30'd0, tlb_write, page_fault}, 32'd0);

        // Walker is usable again after the reset.
        start_walk(32'h0000_3000, 32'h0000_0100);
        check("post_rst_addr", mem_addr, 32'h0000_010C);
        grant_now();
        respond(32'h8000_00AA);
        check("post_rst_phys", {24'd0, reg_physical_page}, 32'h0000_00AA);
        tick();
        tick();
        check("excl_strobes", both_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
